// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, FSM states, op-class helpers.
package muldiv_sequencer_pkg;

   localparam logic [4:0] M_MUL    = 5'b01000;
   localparam logic [4:0] M_MULH   = 5'b01001;
   localparam logic [4:0] M_MULHU  = 5'b01010;
   localparam logic [4:0] M_MULHSU = 5'b01011;
   localparam logic [4:0] M_DIV    = 5'b01100;
   localparam logic [4:0] M_DIVU   = 5'b01101;
   localparam logic [4:0] M_REM    = 5'b01110;
   localparam logic [4:0] M_REMU   = 5'b01111;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_MUL_WAIT = 3'd1,
      ST_DIV_RUN  = 3'd2,
      ST_DIV_FIX  = 3'd3,
      ST_FIN      = 3'd4
   } state_e;

   function automatic logic is_mop(input logic [4:0] op);
      return (op[4:3] == 2'b01);
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return op[2];
   endfunction

   function automatic logic is_rem(input logic [4:0] op);
      return op[2] & op[1];
   endfunction

   // DIV and REM are the signed division ops (bit 0 clear).
   function automatic logic is_signed_div(input logic [4:0] op);
      return op[2] & ~op[0];
   endfunction

   // Full 64-bit product; bits [1:0] of the op select operand signedness.
   function automatic logic [63:0] mul_full(input logic [1:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [63:0] ext_a;
      logic [63:0] ext_b;
      ext_a = (sel == 2'b10) ? {32'd0, a} : {{32{a[31]}}, a};
      ext_b = sel[1] ? {32'd0, b} : {{32{b[31]}}, b};
      return ext_a * ext_b;
   endfunction

   function automatic logic [4:0] partner_op(input logic [4:0] op);
      case (op)
         M_MUL:   return M_MULH;
         M_MULH:  return M_MUL;
         M_DIV:   return M_REM;
         M_REM:   return M_DIV;
         M_DIVU:  return M_REMU;
         M_REMU:  return M_DIVU;
         default: return 5'b00000;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if;
   logic        start;
   logic [4:0]  aluop;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic [31:0] result;
   logic        done;
   logic        busy_wait;

   modport master (output start, aluop, op_a, op_b, flush, input result, done, busy_wait);
   modport slave  (input start, aluop, op_a, op_b, flush, output result, done, busy_wait);
endinterface

// File: rtl/muldiv_sequencer_div_iter_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, 32 steps after load.
module div_iter_core (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic        step_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quot_o,
   output logic [31:0] rem_o
);
   logic [31:0] quot_q, quot_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic [32:0] shifted_s;
   logic [32:0] diff_s;

   // Quotient register doubles as dividend shifter; a borrow in bit 32 means restore.
   always_comb begin
      quot_d    = quot_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      shifted_s = {rem_q, quot_q[31]};
      diff_s    = shifted_s - {1'b0, dvs_q};
      if (load_i) begin
         quot_d = dividend_i;
         rem_d  = 32'd0;
         dvs_d  = divisor_i;
      end else if (step_i && !diff_s[32]) begin
         rem_d  = diff_s[31:0];
         quot_d = {quot_q[30:0], 1'b1};
      end else if (step_i) begin
         rem_d  = shifted_s[31:0];
         quot_d = {quot_q[30:0], 1'b0};
      end else begin
         quot_d = quot_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         quot_q <= 32'd0;
         rem_q  <= 32'd0;
         dvs_q  <= 32'd0;
      end else begin
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
      end
   end

   assign quot_o = quot_q;
   assign rem_o  = rem_q;
endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer: latency-modelled multiplier and restoring divider behind a DONE/BUSY_WAIT handshake.
// Optional MULDIV_REUSE_EN keeps the other result half so a matching partner op completes in one cycle.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int MUL_LATENCY = 2,
   parameter int XLEN        = 32
) (
   input logic               clk_i,
   input logic               rst_ni,
   muldiv_sequencer_if.slave bus
);
   localparam logic [4:0] MUL_LAST_CNT = 5'(MUL_LATENCY > 1 ? MUL_LATENCY - 2 : 0);

   state_e            state_q, state_d;
   logic [4:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              quot_neg_q, quot_neg_d, rem_neg_q, rem_neg_d;
   logic [XLEN-1:0]   result_q;

   logic              accept_s, sdiv_s, div_zero_s, div_ovf_s;
   logic              div_load_s, div_step_s, fin_load_s, reuse_hit_s;
   logic [4:0]        fin_op_s;
   logic [XLEN-1:0]   fin_a_s, fin_b_s, fin_result_s, reuse_other_s;
   logic [63:0]       prod_s;
   logic [XLEN-1:0]   mul_res_s, mag_a_s, mag_b_s, sp_quot_s, sp_rem_s;
   logic [XLEN-1:0]   core_quot_s, core_rem_s, quot_fix_s, rem_fix_s;

   assign accept_s   = (state_q == ST_IDLE) & bus.start & is_mop(bus.aluop) & ~bus.flush;
   assign sdiv_s     = is_signed_div(bus.aluop);
   assign div_zero_s = (bus.op_b == 32'd0);
   assign div_ovf_s  = sdiv_s & (bus.op_a == 32'h8000_0000) & (bus.op_b == 32'hFFFF_FFFF);
   assign sp_quot_s  = div_zero_s ? 32'hFFFF_FFFF : 32'h8000_0000;
   assign sp_rem_s   = div_zero_s ? bus.op_a : 32'd0;
   assign mag_a_s    = (sdiv_s & bus.op_a[31]) ? (32'd0 - bus.op_a) : bus.op_a;
   assign mag_b_s    = (sdiv_s & bus.op_b[31]) ? (32'd0 - bus.op_b) : bus.op_b;

   // In IDLE the live bus operands feed the single multiplier; afterwards the captured ones do.
   assign fin_op_s   = (state_q == ST_IDLE) ? bus.aluop : op_q;
   assign fin_a_s    = (state_q == ST_IDLE) ? bus.op_a  : a_q;
   assign fin_b_s    = (state_q == ST_IDLE) ? bus.op_b  : b_q;
   assign prod_s     = mul_full(fin_op_s[1:0], fin_a_s, fin_b_s);
   assign mul_res_s  = (fin_op_s == M_MUL) ? prod_s[31:0] : prod_s[63:32];
   assign quot_fix_s = quot_neg_q ? (32'd0 - core_quot_s) : core_quot_s;
   assign rem_fix_s  = rem_neg_q  ? (32'd0 - core_rem_s)  : core_rem_s;

   div_iter_core u_div (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (div_load_s),
      .step_i     (div_step_s),
      .dividend_i (mag_a_s),
      .divisor_i  (mag_b_s),
      .quot_o     (core_quot_s),
      .rem_o      (core_rem_s)
   );

   // Next-state, operand capture and result selection; FLUSH overrides everything.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      cnt_d        = cnt_q;
      quot_neg_d   = quot_neg_q;
      rem_neg_d    = rem_neg_q;
      div_load_s   = 1'b0;
      div_step_s   = 1'b0;
      fin_load_s   = 1'b0;
      fin_result_s = result_q;
      if (bus.flush) begin
         state_d = ST_IDLE;
         cnt_d   = 5'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  op_d       = bus.aluop;
                  a_d        = bus.op_a;
                  b_d        = bus.op_b;
                  cnt_d      = 5'd0;
                  quot_neg_d = sdiv_s & (bus.op_a[31] ^ bus.op_b[31]);
                  rem_neg_d  = sdiv_s & bus.op_a[31];
                  if (reuse_hit_s) begin
                     state_d      = ST_FIN;
                     fin_load_s   = 1'b1;
                     fin_result_s = reuse_other_s;
                  end else if (is_div(bus.aluop) && (div_zero_s || div_ovf_s)) begin
                     state_d      = ST_FIN;
                     fin_load_s   = 1'b1;
                     fin_result_s = is_rem(bus.aluop) ? sp_rem_s : sp_quot_s;
                  end else if (is_div(bus.aluop)) begin
                     state_d    = ST_DIV_RUN;
                     div_load_s = 1'b1;
                  end else if (MUL_LATENCY == 1) begin
                     state_d      = ST_FIN;
                     fin_load_s   = 1'b1;
                     fin_result_s = mul_res_s;
                  end else begin
                     state_d = ST_MUL_WAIT;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MUL_WAIT: begin
               if (cnt_q == MUL_LAST_CNT) begin
                  state_d      = ST_FIN;
                  cnt_d        = 5'd0;
                  fin_load_s   = 1'b1;
                  fin_result_s = mul_res_s;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            ST_DIV_RUN: begin
               div_step_s = 1'b1;
               if (cnt_q == 5'd31) begin
                  state_d = ST_DIV_FIX;
                  cnt_d   = 5'd0;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            ST_DIV_FIX: begin
               state_d      = ST_FIN;
               fin_load_s   = 1'b1;
               fin_result_s = is_rem(op_q) ? rem_fix_s : quot_fix_s;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Sequencer state and result registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         op_q       <= 5'd0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         cnt_q      <= 5'd0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         result_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         quot_neg_q <= quot_neg_d;
         rem_neg_q  <= rem_neg_d;
         if (fin_load_s) begin
            result_q <= fin_result_s;
         end
      end
   end

`ifdef MULDIV_REUSE_EN
   logic            saved_valid_q;
   logic [4:0]      saved_op_q;
   logic [XLEN-1:0] saved_a_q, saved_b_q, saved_other_q, fin_other_s;

   assign reuse_hit_s   = saved_valid_q & (partner_op(saved_op_q) == bus.aluop) &
                          (saved_a_q == bus.op_a) & (saved_b_q == bus.op_b);
   assign reuse_other_s = saved_other_q;

   // The half not returned by the op that is completing; on a reuse hit that is the previous result.
   always_comb begin
      fin_other_s = result_q;
      if (state_q == ST_DIV_FIX) begin
         fin_other_s = is_rem(op_q) ? quot_fix_s : rem_fix_s;
      end else if ((state_q == ST_IDLE) && reuse_hit_s) begin
         fin_other_s = result_q;
      end else if (is_div(fin_op_s)) begin
         fin_other_s = is_rem(fin_op_s) ? sp_quot_s : sp_rem_s;
      end else if (fin_op_s == M_MUL) begin
         fin_other_s = prod_s[63:32];
      end else begin
         fin_other_s = prod_s[31:0];
      end
   end

   // Saved-half record; FLUSH invalidates it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         saved_valid_q <= 1'b0;
         saved_op_q    <= 5'd0;
         saved_a_q     <= 32'd0;
         saved_b_q     <= 32'd0;
         saved_other_q <= 32'd0;
      end else if (bus.flush) begin
         saved_valid_q <= 1'b0;
      end else if (fin_load_s) begin
         saved_valid_q <= 1'b1;
         saved_op_q    <= fin_op_s;
         saved_a_q     <= fin_a_s;
         saved_b_q     <= fin_b_s;
         saved_other_q <= fin_other_s;
      end
   end
`else
   assign reuse_hit_s   = 1'b0;
   assign reuse_other_s = 32'd0;
`endif

   assign bus.result    = result_q;
   assign bus.done      = (state_q == ST_FIN);
   assign bus.busy_wait = rst_ni & ~bus.flush &
                          (((state_q == ST_IDLE) & bus.start & is_mop(bus.aluop)) |
                           (state_q == ST_MUL_WAIT) | (state_q == ST_DIV_RUN) |
                           (state_q == ST_DIV_FIX));
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
   localparam int MUL_LAT = 2;
`ifdef MULDIV_REUSE_EN
   localparam bit REUSE_ON = 1'b1;
`else
   localparam bit REUSE_ON = 1'b0;
`endif
   localparam logic [4:0] OP_MUL = 5'b01000, OP_MULH = 5'b01001, OP_MULHU = 5'b01010,
                          OP_MULHSU = 5'b01011, OP_DIV = 5'b01100, OP_DIVU = 5'b01101,
                          OP_REM = 5'b01110, OP_REMU = 5'b01111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] prev_result = 32'd0;
   bit          last_valid = 1'b0;
   logic [4:0]  last_op = 5'd0;
   logic [31:0] last_a = 32'd0;
   logic [31:0] last_b = 32'd0;

   muldiv_sequencer_if bus();

   muldiv_sequencer #(.MUL_LATENCY(MUL_LAT), .XLEN(32)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      bit          ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OP_MUL:    begin p = sa * sb; return p[31:0];  end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHU:  begin p = ua * ub; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_DIV:    return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
         OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:    return (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         OP_REMU:   return (b == 32'd0) ? a : a % b;
         default:   return 32'd0;
      endcase
   endfunction

   function automatic bit is_pair(input logic [4:0] x, input logic [4:0] y);
      return (x == OP_MUL && y == OP_MULH) || (x == OP_MULH && y == OP_MUL) ||
             (x == OP_DIV && y == OP_REM)  || (x == OP_REM && y == OP_DIV)  ||
             (x == OP_DIVU && y == OP_REMU) || (x == OP_REMU && y == OP_DIVU);
   endfunction

   function automatic int exp_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (REUSE_ON && last_valid && is_pair(last_op, op) && a == last_a && b == last_b) return 1;
      if (op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU}) return MUL_LAT;
      if (b == 32'd0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Issue one op, optionally poking START again mid-flight, and check latency, result and handshakes.
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input string tag);
      int          lat;
      int          k;
      logic [31:0] exp;
      lat = exp_latency(op, a, b);
      exp = ref_result(op, a, b);
      @(negedge clk);
      #1 check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
      bus.start = 1'b1; bus.aluop = op; bus.op_a = a; bus.op_b = b;
      #1 check({tag, "_busy_accept"}, 32'(bus.busy_wait), 32'd1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
         bus.start = 1'b0;
         if (k == poke_at) begin
            bus.start = 1'b1; bus.aluop = OP_MULHU; bus.op_a = $urandom; bus.op_b = $urandom;
         end
         #1;
         if (!bus.done) begin
            check({tag, "_busy_wait"}, 32'(bus.busy_wait), 32'd1);
            check({tag, "_result_hold"}, bus.result, prev_result);
         end
      end while (!bus.done && k < 60);
      check({tag, "_latency"}, 32'(k), 32'(lat));
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_result"}, bus.result, exp);
      check({tag, "_busy_in_done"}, 32'(bus.busy_wait), 32'd0);
      prev_result = exp;
      last_valid = 1'b1; last_op = op; last_a = a; last_b = b;
   endtask

   // Abort a DIV with FLUSH (or RESET when use_reset is set) at cycle N+at; no DONE may follow.
   task automatic abort_div(input int at, input bit use_reset, input string tag);
      @(negedge clk);
      bus.start = 1'b1; bus.aluop = OP_DIV; bus.op_a = 32'd5000; bus.op_b = 32'd13;
      #1 check({tag, "_busy_accept"}, 32'(bus.busy_wait), 32'd1);
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (use_reset) begin
            if (k == at) rst_n = 1'b0;
            if (k == at + 2) rst_n = 1'b1;
            if (k == at) prev_result = 32'd0;
         end else begin
            bus.flush = (k == at);
         end
         #1;
         check({tag, "_busy"}, 32'(bus.busy_wait), (k < at) ? 32'd1 : 32'd0);
         check({tag, "_no_done"}, 32'(bus.done), 32'd0);
         check({tag, "_result"}, bus.result, prev_result);
      end
      last_valid = 1'b0;
   endtask

   task automatic flush_pulse();
      @(negedge clk); bus.flush = 1'b1;
      @(negedge clk); bus.flush = 1'b0;
      last_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      bus.start = 1'b0; bus.aluop = OP_MUL; bus.op_a = 32'd0; bus.op_b = 32'd0; bus.flush = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      #1;
      check("rst_result", bus.result, 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_busy", 32'(bus.busy_wait), 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      do_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 0, "mul_7_m3");
      do_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         0, "div_m7_2");
      do_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         0, "rem_m7_2");
      do_op(OP_DIVU,   32'd100,        32'd7,         0, "divu_100_7");
      do_op(OP_REMU,   32'd100,        32'd7,         0, "remu_100_7");
      do_op(OP_DIVU,   32'd5,          32'd0,         0, "divu_by0");
      do_op(OP_REM,    32'd5,          32'd0,         0, "rem_by0");
      do_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 0, "div_ovf");
      do_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 0, "rem_ovf");
      do_op(OP_MULH,   32'hFFFF_FFFF,  32'd2,         0, "mulh");
      do_op(OP_MULHU,  32'hFFFF_FFFF,  32'd2,         0, "mulhu");
      do_op(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         0, "mulhsu");
      do_op(OP_DIVU,   32'd1000,       32'd9,         5, "start_busy");

      abort_div(10, 1'b0, "flush_mid");
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.aluop = OP_MUL; bus.op_a = 32'd3; bus.op_b = 32'd4;
      #1 check("flush_start_busy", 32'(bus.busy_wait), 32'd0);
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1 check("flush_start_no_done", 32'(bus.done), 32'd0);
      end
      last_valid = 1'b0;
      abort_div(5, 1'b1, "reset_mid");

      do_op(OP_DIV, 32'd100, 32'd7, 0, "reuse_div");
      do_op(OP_REM, 32'd100, 32'd7, 0, "reuse_rem");
      do_op(OP_DIV, 32'd100, 32'd7, 0, "reuse_div2");
      flush_pulse();
      do_op(OP_REM, 32'd100, 32'd7, 0, "reuse_rem_flushed");

      for (int i = 0; i < 40; i++) begin
         rop = 5'(8 + $urandom_range(0, 7));
         ra  = pick_operand();
         rb  = pick_operand();
         do_op(rop, ra, rb, 0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
